serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. It sequences one external single-bit full_adder cell (a, b, i -> s, c) over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- It owns the operand shift registers, the carry flip-flop, the result shift register and the start/done handshake.
- It sits between a requester issuing add commands and the shared 1-bit full_adder datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command strobe; accepted only when ready=1.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- cin  input  1  carry-in, sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  carry out of the MSB; holds like sum.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); holds like sum.
- fa_a  output  1  to full_adder a.
- fa_b  output  1  to full_adder b.
- fa_i  output  1  to full_adder carry-in i.
- fa_s  input  1  from full_adder sum s.
- fa_c  input  1  from full_adder carry c.

Behaviour:
- Reset (rst=1 at a rising edge), including mid-operation:
  - state=IDLE; shift regs, carry reg, bit counter cleared.
  - sum=0, cout=0, ovf=0, done=0, busy=0, ready=1.
  - In-flight operation discarded; no done pulse.
- Bit counter width is clog2(WIDTH) (minimum 1).
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1, busy=0.
  - start=1 at an edge: load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, state<=RUN.
  - sum, cout and ovf are not cleared at accept; they hold the previous result until overwritten in RUN.
- RUN (exactly WIDTH cycles):
  - Combinationally: fa_a=A_sr[0], fa_b=B_sr[0], fa_i=carry.
  - Each edge: sum<={fa_s, sum[WIDTH-1:1]}; A_sr>>=1; B_sr>>=1; carry<=fa_c; cnt<=cnt+1.
  - At the edge where cnt==WIDTH-1: cout<=fa_c, ovf<=fa_i^fa_c, state<=DONE.
  - sum is partially shifted and not valid during RUN.
- DONE (one cycle):
  - done=1, busy=1, ready=0; sum/cout/ovf valid.
  - Next edge -> IDLE unconditionally.
- fa_a, fa_b and fa_i are 0 outside RUN.
- start while busy=1 (RUN or DONE) is ignored: no queuing, no effect on operands.
- Timing, with the accepting edge E0:
  - RUN occupies E0..E0+WIDTH.
  - done=1 between edges E0+WIDTH and E0+WIDTH+1.
  - Earliest next accept is at E0+WIDTH+2.
  - Throughput is one add per WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- WIDTH=1: RUN lasts exactly 1 cycle; ovf = cin^cout.
- a, b and cin may change freely after the accepting edge with no effect on the result.
- fa_s and fa_c are assumed combinational from fa_a, fa_b and fa_i within the same cycle. The block adds no register on the datapath return.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> done after 8 RUN cycles. Result sum=0x8D, cout=0, ovf=1. First RUN cycle drives fa_a=0, fa_b=1, fa_i=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Carry propagates through all 8 cycles (fa_i=1 from cycle 2 onward).
- a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- Start held high continuously with a/b changing every cycle -> only IDLE-edge values used. done is exactly one cycle wide. Accepts spaced exactly 10 cycles apart. Previous sum holds until the next RUN begins.
- rst=1 on the 4th RUN cycle of 0xFF+0x01 -> next cycle: ready=1, sum=0, cout=0, no done pulse. A following 0x01+0x01 yields sum=0x02.
- Exhaustive sweep, WIDTH=4: all 512 (a,b,cin) triples -> {cout,sum}==a+b+cin and ovf matches the signed rule for every case.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller driving an external 1-bit full adder
//
// Sequences one shared single-bit full_adder cell over WIDTH cycles to add two
// WIDTH-bit operands LSB first, with a start/ready/done handshake.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, a, b, cin    command strobe and operands, captured when ready=1
//   ready, busy, done   IDLE / RUN+DONE / one-cycle completion pulse
//   sum, cout, ovf      result, carry out, signed overflow; held until next accept
//   fa_a, fa_b, fa_i    operand and carry bits presented to the full adder
//   fa_s, fa_c          sum and carry returned combinationally by the full adder
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_i,
  input  logic             fa_s,
  input  logic             fa_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;
  logic             ovf_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             run;
  logic             last_bit;

  always_comb begin
    run      = (state_q == S_RUN);
    // Datapath inputs are gated so the shared adder sees zeros outside RUN.
    fa_a     = run & a_sr_q[0];
    fa_b     = run & b_sr_q[0];
    fa_i     = run & carry_q;
    // New sum bit enters at the MSB; written this way it also covers WIDTH=1.
    sum_d    = WIDTH'({fa_s, sum_q} >> 1);
    last_bit = (cnt_q == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Previous sum/cout/ovf stay visible until RUN overwrites them.
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // fa_i is the carry into the MSB on this cycle.
            cout_q  <= fa_c;
            ovf_q   <= fa_i ^ fa_c;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=4)
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic       fa_a8, fa_b8, fa_i8, fa_s8, fa_c8;

  // WIDTH=4 instance
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       ready4, busy4, done4, cout4, ovf4;
  logic       fa_a4, fa_b4, fa_i4, fa_s4, fa_c4;

  // External full adder cells
  assign fa_s8 = fa_a8 ^ fa_b8 ^ fa_i8;
  assign fa_c8 = (fa_a8 & fa_b8) | (fa_a8 & fa_i8) | (fa_b8 & fa_i8);
  assign fa_s4 = fa_a4 ^ fa_b4 ^ fa_i4;
  assign fa_c4 = (fa_a4 & fa_b4) | (fa_a4 & fa_i4) | (fa_b4 & fa_i4);

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_i(fa_i8), .fa_s(fa_s8), .fa_c(fa_c8)
  );

  serial_add_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_i(fa_i4), .fa_s(fa_s4), .fa_c(fa_c4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum and the signed-range overflow rule.
  function automatic int ref_total(input int w, input int av, input int bv, input int cv);
    return (av + bv + cv) % (1 << (w + 1));
  endfunction

  function automatic int ref_ovf(input int w, input int av, input int bv, input int cv);
    int sa, sb, r, lo, hi;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r  = sa + sb + cv;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    return (r < lo || r > hi) ? 1 : 0;
  endfunction

  // Carry entering bit k when adding the low k bits of the operands.
  function automatic int ref_carry_in(input int k, input int av, input int bv, input int cv);
    int m;
    m = (1 << k) - 1;
    return (((av & m) + (bv & m) + cv) >> k) & 1;
  endfunction

  task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int tot;
    tot = ref_total(8, int'(av), int'(bv), int'(cv));
    start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      chk("run_fa_a", fa_a8, av[k]);
      chk("run_fa_b", fa_b8, bv[k]);
      chk("run_fa_i", fa_i8, 64'(ref_carry_in(k, int'(av), int'(bv), int'(cv))));
      chk("run_flags", {ready8, busy8, done8}, 3'b010);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
    end
    chk("done_flags", {ready8, busy8, done8}, 3'b011);
    chk("sum8", sum8, 64'(tot & 8'hFF));
    chk("cout8", cout8, 64'(tot >> 8));
    chk("ovf8", ovf8, 64'(ref_ovf(8, int'(av), int'(bv), int'(cv))));
    @(posedge clk); #1;
    chk("idle_flags", {ready8, busy8, done8}, 3'b100);
    chk("idle_fa", {fa_a8, fa_b8, fa_i8}, 3'b000);
    chk("sum8_hold", {cout8, sum8}, 64'(tot));
  endtask

  task automatic add4(input logic [3:0] av, input logic [3:0] bv, input logic cv);
    int tot;
    tot = ref_total(4, int'(av), int'(bv), int'(cv));
    start4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    repeat (4) @(posedge clk);
    #1;
    chk("w4_done", {ready4, busy4, done4}, 3'b011);
    chk("w4_sum_cout", {cout4, sum4}, 64'(tot));
    chk("w4_ovf", ovf4, 64'(ref_ovf(4, int'(av), int'(bv), int'(cv))));
    @(posedge clk); #1;
  endtask

  logic [7:0] va [0:30];
  logic [7:0] vb [0:30];
  logic       vc [0:30];

  initial begin
    int tot, base;
    bit saw_done;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags8", {ready8, busy8, done8}, 3'b100);
    chk("rst_res8", {cout8, ovf8, sum8}, 10'h000);
    chk("rst_fa8", {fa_a8, fa_b8, fa_i8}, 3'b000);
    chk("rst_flags4", {ready4, busy4, done4}, 3'b100);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    add8(8'h5A, 8'h33, 1'b0);
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'h7F, 8'h00, 1'b1);
    add8(8'h80, 8'h80, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1);
    add8(8'h00, 8'h00, 1'b0);

    // Random cases
    for (int n = 0; n < 30; n++) add8(8'($urandom), 8'($urandom), 1'($urandom));

    // start held high with operands changing every cycle
    va[0] = 8'($urandom); vb[0] = 8'($urandom); vc[0] = 1'($urandom);
    a8 = va[0]; b8 = vb[0]; cin8 = vc[0]; start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("held_done", done8, 64'(i % 10 == 8));
      chk("held_ready", ready8, 64'(i % 10 == 9));
      if (i % 10 == 8) begin
        base = i - 8;
        tot  = ref_total(8, int'(va[base]), int'(vb[base]), int'(vc[base]));
        chk("held_result", {cout8, sum8}, 64'(tot));
        chk("held_ovf", ovf8, 64'(ref_ovf(8, int'(va[base]), int'(vb[base]), int'(vc[base]))));
      end
      if (i >= 9 && (i % 10 == 9 || i % 10 == 0)) begin
        base = ((i - 9) / 10) * 10;
        tot  = ref_total(8, int'(va[base]), int'(vb[base]), int'(vc[base]));
        chk("held_sum_hold", {cout8, sum8}, 64'(tot));
      end
      va[i+1] = 8'($urandom); vb[i+1] = 8'($urandom); vc[i+1] = 1'($urandom);
      a8 = va[i+1]; b8 = vb[i+1]; cin8 = vc[i+1];
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    chk("held_end_idle", {ready8, busy8, done8}, 3'b100);

    // Reset during the 4th RUN cycle of 0xFF+0x01
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_flags", {ready8, busy8, done8}, 3'b100);
    chk("midrst_res", {cout8, ovf8, sum8}, 10'h000);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done8) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", saw_done, 1'b0);
    add8(8'h01, 8'h01, 1'b0);

    // Exhaustive WIDTH=4 sweep
    for (int t = 0; t < 512; t++) add4(4'(t & 15), 4'((t >> 4) & 15), 1'(t >> 8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
